// File: rtl/demux1x2_stream.sv
// Routes one upstream stream into two independent 2-deep FIFO channels chosen by in_sel.
// Each channel back-pressures only the words addressed to it; outputs are driven straight from registers.
module demux1x2_stream #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sel,
    input  logic [N-1:0] in_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [N-1:0] out0_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [N-1:0] out1_data,
    output logic [1:0]   cnt0,
    output logic [1:0]   cnt1
);

    logic [1:0]   ch_ready;
    logic [1:0]   ch_valid;
    logic [1:0]   ch_full;
    logic [N-1:0] ch_data [2];
    logic [1:0]   ch_cnt  [2];

    assign ch_ready = {out1_ready, out0_ready};

    // Ready looks only at the addressed channel's occupancy, never at downstream ready.
    assign in_ready = ~ch_full[in_sel];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [N-1:0] mem_reg [2];
            logic         wptr_reg;
            logic         rptr_reg;
            logic [1:0]   cnt_reg;
            logic         push;
            logic         pop;

            assign push = in_valid && !ch_full[gi] && (in_sel == 1'(gi));
            assign pop  = ch_valid[gi] && ch_ready[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[0] <= '0;
                    mem_reg[1] <= '0;
                    wptr_reg   <= 1'b0;
                    rptr_reg   <= 1'b0;
                    cnt_reg    <= 2'd0;
                end else begin
                    if (push) begin
                        mem_reg[wptr_reg] <= in_data;
                        wptr_reg          <= ~wptr_reg;
                    end
                    if (pop) begin
                        rptr_reg <= ~rptr_reg;
                    end
                    case ({push, pop})
                        2'b10:   cnt_reg <= cnt_reg + 2'd1;
                        2'b01:   cnt_reg <= cnt_reg - 2'd1;
                        default: cnt_reg <= cnt_reg;
                    endcase
                end
            end

            assign ch_full[gi]  = (cnt_reg == 2'd2);
            assign ch_valid[gi] = (cnt_reg != 2'd0);
            assign ch_data[gi]  = mem_reg[rptr_reg];
            assign ch_cnt[gi]   = cnt_reg;
        end
    endgenerate

    assign out0_valid = ch_valid[0];
    assign out1_valid = ch_valid[1];
    assign out0_data  = ch_data[0];
    assign out1_data  = ch_data[1];
    assign cnt0       = ch_cnt[0];
    assign cnt1       = ch_cnt[1];

endmodule

// File: tb/tb_demux1x2_stream.sv
// Drives directed and random traffic into demux1x2_stream and compares against per-channel queues.
module tb_demux1x2_stream;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [N-1:0] in_data;
    logic         out0_valid, out0_ready;
    logic [N-1:0] out0_data;
    logic         out1_valid, out1_ready;
    logic [N-1:0] out1_data;
    logic [1:0]   cnt0, cnt1;

    demux1x2_stream #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] q0[$];
    logic [N-1:0] q1[$];
    logic [N-1:0] popped0[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = in_sel ? q1.size() : q0.size();
        check("valid0", 32'(out0_valid), 32'(q0.size() != 0));
        check("valid1", 32'(out1_valid), 32'(q1.size() != 0));
        check("cnt0", 32'(cnt0), 32'(q0.size()));
        check("cnt1", 32'(cnt1), 32'(q1.size()));
        check("in_ready", 32'(in_ready), 32'(sz < 2));
        if (q0.size() != 0) check("data0", out0_data, q0[0]);
        if (q1.size() != 0) check("data1", out1_data, q1[0]);
    endtask

    // Called just after a rising edge; applies inputs for one clock and advances the model.
    task automatic cycle(input logic v, input logic s, input logic [N-1:0] d,
                         input logic r0, input logic r1);
        logic acc, p0, p1;
        in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
        @(negedge clk);
        check_model();
        acc = v && ((s ? q1.size() : q0.size()) < 2);
        p0  = r0 && (q0.size() != 0);
        p1  = r1 && (q1.size() != 0);
        @(posedge clk);
        #1;
        if (p0) popped0.push_back(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_v0"}, 32'(out0_valid), 32'd0);
        check({tag, "_v1"}, 32'(out1_valid), 32'd0);
        check({tag, "_d0"}, out0_data, 32'd0);
        check({tag, "_d1"}, out1_data, 32'd0);
        check({tag, "_c0"}, 32'(cnt0), 32'd0);
        check({tag, "_c1"}, 32'(cnt1), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // Routing to each channel
        cycle(1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b0);
        check("route_d0", out0_data, 32'hA5A5A5A5);
        check("route_d1", out1_data, 32'h5A5A5A5A);
        check("route_c0", 32'(cnt0), 32'd1);
        check("route_c1", 32'(cnt1), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Full channel stalls only its own traffic
        cycle(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h3;
        #1;
        check("full_rdy0", 32'(in_ready), 32'd0);
        check("full_cnt0", 32'(cnt0), 32'd2);
        in_sel = 1'b1;
        #1;
        check("full_rdy1", 32'(in_ready), 32'd1);
        cycle(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
        check("stall_c1", 32'(cnt1), 32'd1);
        check("stall_d1", out1_data, 32'h3);
        popped0.delete();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("order_n", popped0.size(), 32'd2);
        if (popped0.size() == 2) begin
            check("order_0", popped0[0], 32'h1);
            check("order_1", popped0[1], 32'h2);
        end

        // Push and pop on the same channel in one cycle
        cycle(1'b1, 1'b1, 32'h7, 1'b0, 1'b1);
        check("simul_c1", 32'(cnt1), 32'd1);
        check("simul_d1", out1_data, 32'h7);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Stream 0..9 through channel 0 with a toggling consumer
        popped0.delete();
        begin
            int k = 0;
            guard = 0;
            while ((popped0.size() < 10) && (guard < 200)) begin
                logic [N-1:0] wd;
                logic wv, acc;
                wd = 32'(k);
                wv = (k < 10);
                acc = wv && (q0.size() < 2);
                cycle(wv, 1'b0, wd, guard[0], 1'b0);
                if (acc) k++;
                check("wrap_cnt_le2", 32'(cnt0 <= 2'd2), 32'd1);
                guard++;
            end
        end
        check("wrap_n", popped0.size(), 32'd10);
        for (int i = 0; i < popped0.size() && i < 10; i++)
            check("wrap_seq", popped0[i], 32'(i));

        // Asynchronous reset with words buffered
        cycle(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h33, 1'b0, 1'b0);
        check("pre_rst_c0", 32'(cnt0), 32'd2);
        check("pre_rst_c1", 32'(cnt1), 32'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("arst");
        q0.delete(); q1.delete();
        @(posedge clk);
        #1;
        check_reset_state("arst_hold");
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
